// File: rtl/vector_result_packer.sv
// Packs the vector adder's 8-bit element stream into byte-masked SRAM words.
// Words pass through a one-entry staging register into a small FIFO, then go out on a valid/ready write port.
module vector_result_packer #(
  parameter int DATA_BIT   = 8,
  parameter int PACK_NUM   = 8,
  parameter int ADDR_WIDTH = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [DATA_BIT-1:0]                      in_data,
  input  logic                                     in_data_vld,
  input  logic [ADDR_WIDTH-1:0]                    in_data_addr,
  input  logic                                     in_finish,
  output logic [DATA_BIT*PACK_NUM-1:0]             wr_data,
  output logic [PACK_NUM-1:0]                      wr_byte_en,
  output logic [ADDR_WIDTH-$clog2(PACK_NUM)-1:0]   wr_addr,
  output logic                                     wr_vld,
  input  logic                                     wr_rdy,
  output logic                                     out_finish,
  output logic                                     overflow,
  output logic                                     busy
);
  localparam int LANE_W  = $clog2(PACK_NUM);
  localparam int WORD_W  = DATA_BIT * PACK_NUM;
  localparam int WADDR_W = ADDR_WIDTH - LANE_W;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_t;
  state_t state;

  logic               open;
  logic [WADDR_W-1:0] pk_addr;
  logic [WORD_W-1:0]  pk_data;
  logic [PACK_NUM-1:0] pk_mask;

  logic               stg_vld;
  logic [WADDR_W-1:0] stg_addr;
  logic [WORD_W-1:0]  stg_data;
  logic [PACK_NUM-1:0] stg_mask;

  logic [WADDR_W-1:0]  mem_addr [FIFO_DEPTH];
  logic [WORD_W-1:0]   mem_data [FIFO_DEPTH];
  logic [PACK_NUM-1:0] mem_mask [FIFO_DEPTH];
  logic [PTR_W:0]      wr_ptr, rd_ptr;

  logic finish_q;
  logic empty, full, pop, accept;

  logic [WADDR_W-1:0]  in_word;
  logic [LANE_W-1:0]   in_lane;
  logic                open_nxt, push;
  logic [WADDR_W-1:0]  pk_addr_nxt, push_addr;
  logic [WORD_W-1:0]   data_nxt, push_data, base_data, ins_data;
  logic [PACK_NUM-1:0] mask_nxt, push_mask, base_mask, ins_mask;

  assign in_word = in_data_addr[ADDR_WIDTH-1:LANE_W];
  assign in_lane = in_data_addr[LANE_W-1:0];

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop    = wr_vld && wr_rdy;
  assign accept = stg_vld && (!full || pop);

  assign wr_vld     = !empty;
  assign wr_addr    = mem_addr[rd_ptr[PTR_W-1:0]];
  assign wr_data    = mem_data[rd_ptr[PTR_W-1:0]];
  assign wr_byte_en = mem_mask[rd_ptr[PTR_W-1:0]];
  assign busy       = open || stg_vld || !empty || (state != IDLE);

  always_comb begin
    open_nxt    = open;
    pk_addr_nxt = pk_addr;
    data_nxt    = pk_data;
    mask_nxt    = pk_mask;
    push        = 1'b0;
    push_addr   = pk_addr;
    push_data   = pk_data;
    push_mask   = pk_mask;
    base_data   = pk_data;
    base_mask   = pk_mask;
    ins_data    = pk_data;
    ins_mask    = pk_mask;
    if (in_data_vld) begin
      if (!open || in_word != pk_addr) begin
        base_data = '0;
        base_mask = '0;
      end
      if (open && in_word != pk_addr) push = 1'b1;
      ins_data = base_data;
      for (int k = 0; k < PACK_NUM; k++)
        if (LANE_W'(k) == in_lane) ins_data[k*DATA_BIT +: DATA_BIT] = in_data;
      ins_mask    = base_mask | (PACK_NUM'(1) << in_lane);
      pk_addr_nxt = in_word;
      data_nxt    = ins_data;
      mask_nxt    = ins_mask;
      open_nxt    = 1'b1;
      if (&ins_mask && !push) begin
        push      = 1'b1;
        push_addr = in_word;
        push_data = ins_data;
        push_mask = ins_mask;
        open_nxt  = 1'b0;
      end
    end else if (state == FLUSH && open && !stg_vld && !full) begin
      // Flush only when the staged word is guaranteed a FIFO slot, so it never drops.
      push     = 1'b1;
      open_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open     <= 1'b0;
      pk_addr  <= '0;
      pk_data  <= '0;
      pk_mask  <= '0;
      stg_vld  <= 1'b0;
      stg_addr <= '0;
      stg_data <= '0;
      stg_mask <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_addr[i] <= '0;
        mem_data[i] <= '0;
        mem_mask[i] <= '0;
      end
    end else begin
      open     <= open_nxt;
      pk_addr  <= pk_addr_nxt;
      pk_data  <= data_nxt;
      pk_mask  <= mask_nxt;
      stg_vld  <= push;
      stg_addr <= push_addr;
      stg_data <= push_data;
      stg_mask <= push_mask;
      if (accept) begin
        mem_addr[wr_ptr[PTR_W-1:0]] <= stg_addr;
        mem_data[wr_ptr[PTR_W-1:0]] <= stg_data;
        mem_mask[wr_ptr[PTR_W-1:0]] <= stg_mask;
        wr_ptr <= wr_ptr + 1'b1;
      end else if (stg_vld) begin
        overflow <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      finish_q   <= 1'b0;
      out_finish <= 1'b0;
    end else begin
      finish_q   <= in_finish;
      out_finish <= 1'b0;
      case (state)
        IDLE:
          if (in_finish && !finish_q) state <= FLUSH;
        FLUSH:
          if (!open && !stg_vld && empty && !in_data_vld) begin
            state      <= DONE;
            out_finish <= 1'b1;
          end
        default:
          state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_result_packer.sv
// Scoreboard bench for vector_result_packer: expected words queued at stimulus, checked on each SRAM write.
module tb_vector_result_packer;
  typedef struct {
    logic [9:0]  addr;
    logic [7:0]  be;
    logic [63:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_data_vld;
  logic [12:0] in_data_addr;
  logic        in_finish;
  logic [63:0] wr_data;
  logic [7:0]  wr_byte_en;
  logic [9:0]  wr_addr;
  logic        wr_vld;
  logic        wr_rdy;
  logic        out_finish;
  logic        overflow;
  logic        busy;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [63:0] mon_m;

  vector_result_packer dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_data_vld(in_data_vld),
    .in_data_addr(in_data_addr), .in_finish(in_finish), .wr_data(wr_data),
    .wr_byte_en(wr_byte_en), .wr_addr(wr_addr), .wr_vld(wr_vld), .wr_rdy(wr_rdy),
    .out_finish(out_finish), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // Compare only the lanes the mask enables; untouched lanes carry no meaning.
  always @(negedge clk) begin
    if (rst_n && wr_vld && wr_rdy) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write addr=%h be=%h data=%h", wr_addr, wr_byte_en, wr_data);
      end else begin
        mon_e = sb.pop_front();
        for (int b = 0; b < 8; b++) mon_m[b*8 +: 8] = {8{mon_e.be[b]}};
        if (wr_addr !== mon_e.addr || wr_byte_en !== mon_e.be ||
            (wr_data & mon_m) !== (mon_e.data & mon_m)) begin
          bad++;
          $display("FAIL write got addr=%h be=%h data=%h want addr=%h be=%h data=%h",
                   wr_addr, wr_byte_en, wr_data, mon_e.addr, mon_e.be, mon_e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [12:0] a, input logic [7:0] d);
    in_data_vld  = 1'b1;
    in_data_addr = a;
    in_data      = d;
    tick();
    in_data_vld  = 1'b0;
  endtask

  function automatic void push_exp(input logic [9:0] a, input logic [7:0] be, input logic [63:0] d);
    exp_t e;
    e.addr = a;
    e.be   = be;
    e.data = d;
    sb.push_back(e);
  endfunction

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_drain got %0d pending want 0", name, sb.size());
    end
  endtask

  task automatic wait_finish(input string name);
    logic got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (out_finish) got = 1'b1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s_finish got no pulse want pulse", name);
    end else begin
      total++;
      if (sb.size() != 0) begin
        bad++;
        $display("FAIL %s_finish_early got %0d pending want 0", name, sb.size());
      end
      @(negedge clk);
      total++;
      if (out_finish !== 1'b0) begin
        bad++;
        $display("FAIL %s_finish_width got %b want 0", name, out_finish);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({wr_vld, wr_byte_en, wr_addr, wr_data, out_finish, overflow, busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got vld=%b be=%h addr=%h data=%h fin=%b ovf=%b busy=%b want all 0",
               wr_vld, wr_byte_en, wr_addr, wr_data, out_finish, overflow, busy);
    end
  endtask

  task automatic test_full_word();
    wr_rdy = 1'b1;
    push_exp(10'h002, 8'hFF, 64'h0807060504030201);
    for (int i = 0; i < 8; i++) send(13'(16 + i), 8'(i + 1));
    @(negedge clk);
    total++;
    if (wr_vld !== 1'b0) begin
      bad++;
      $display("FAIL latency_early got wr_vld=%b want 0", wr_vld);
    end
    @(negedge clk);
    total++;
    if (wr_vld !== 1'b1) begin
      bad++;
      $display("FAIL latency_vld got wr_vld=%b want 1", wr_vld);
    end
    wait_drain("full_word");
  endtask

  task automatic test_addr_change_flush();
    wr_rdy = 1'b1;
    push_exp(10'h004, 8'h03, 64'h000000000000BBAA);
    push_exp(10'h006, 8'h01, 64'h00000000000000CC);
    send(13'h020, 8'hAA);
    send(13'h021, 8'hBB);
    send(13'h030, 8'hCC);
    in_finish = 1'b1;
    tick();
    in_finish = 1'b0;
    wait_finish("addr_change");
  endtask

  task automatic test_duplicate_lane();
    wr_rdy = 1'b1;
    push_exp(10'h005, 8'h08, 64'h0000000022000000);
    send(13'h02B, 8'h11);
    send(13'h02B, 8'h22);
    in_finish = 1'b1;
    tick();
    in_finish = 1'b0;
    wait_finish("dup_lane");
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL dup_lane_overflow got %b want 0", overflow);
    end
  endtask

  task automatic test_finish_same_cycle();
    wr_rdy = 1'b1;
    push_exp(10'h3FF, 8'h80, 64'h7F00000000000000);
    in_data_vld  = 1'b1;
    in_data_addr = 13'h1FFF;
    in_data      = 8'h7F;
    in_finish    = 1'b1;
    tick();
    in_data_vld  = 1'b0;
    in_finish    = 1'b0;
    wait_finish("same_cycle");
    tick();
    in_finish = 1'b1;
    tick();
    in_finish = 1'b0;
    @(negedge clk);
    total++;
    if (out_finish !== 1'b0) begin
      bad++;
      $display("FAIL empty_finish_early got %b want 0", out_finish);
    end
    @(negedge clk);
    total++;
    if (out_finish !== 1'b1) begin
      bad++;
      $display("FAIL empty_finish_pulse got %b want 1", out_finish);
    end
    @(negedge clk);
    total++;
    if (out_finish !== 1'b0) begin
      bad++;
      $display("FAIL empty_finish_width got %b want 0", out_finish);
    end
  endtask

  task automatic test_overflow_stall();
    logic [63:0] d;
    logic [81:0] head;
    wr_rdy = 1'b0;
    for (int w = 0; w < 5; w++) begin
      for (int l = 0; l < 8; l++) d[l*8 +: 8] = 8'(w * 16 + l);
      if (w < 4) push_exp(10'(16 + w), 8'hFF, d);
      for (int l = 0; l < 8; l++) send(13'((16 + w) * 8 + l), 8'(w * 16 + l));
    end
    repeat (3) tick();
    @(negedge clk);
    total++;
    if (overflow !== 1'b1 || wr_vld !== 1'b1) begin
      bad++;
      $display("FAIL overflow_set got ovf=%b vld=%b want ovf=1 vld=1", overflow, wr_vld);
    end
    head = {wr_addr, wr_byte_en, wr_data};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({wr_addr, wr_byte_en, wr_data} !== head) begin
        bad++;
        $display("FAIL stall_stable got %h want %h", {wr_addr, wr_byte_en, wr_data}, head);
      end
    end
    tick();
    wr_rdy = 1'b1;
    wait_drain("overflow");
    repeat (3) @(negedge clk);
  endtask

  task automatic test_async_reset();
    logic seen_vld = 1'b0;
    wr_rdy = 1'b0;
    for (int w = 0; w < 2; w++)
      for (int l = 0; l < 8; l++) send(13'((32 + w) * 8 + l), 8'(l));
    send(13'h110, 8'h55);
    repeat (3) tick();
    total++;
    if (wr_vld !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset got vld=%b busy=%b want 1 1", wr_vld, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (wr_vld !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got vld=%b busy=%b ovf=%b want 0 0 0", wr_vld, busy, overflow);
    end
    tick();
    tick();
    rst_n  = 1'b1;
    wr_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wr_vld !== 1'b0) seen_vld = 1'b1;
    end
    total++;
    if (seen_vld !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL stale_after_reset got vld_seen=%b busy=%b want 0 0", seen_vld, busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n        = 1'b0;
    in_data      = '0;
    in_data_vld  = 1'b0;
    in_data_addr = '0;
    in_finish    = 1'b0;
    wr_rdy       = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    test_reset();
    test_full_word();
    test_addr_change_flush();
    test_duplicate_lane();
    test_finish_same_cycle();
    test_overflow_stall();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vector_result_packer.md
Name: vector_result_packer

Overview:
Downstream stage of the vector adder. It consumes the adder's quantized 8-bit element stream: data, valid, 13-bit element address and finish. It packs elements into 64-bit byte-masked words keyed by word address, buffers them in a small FIFO, and issues them to the global SRAM write port using a valid/ready handshake. When the finish flush completes, it emits a single-cycle completion pulse.

Parameters:
DATA_BIT, 8, width of one element
PACK_NUM, 8, elements per packed word (power of 2)
ADDR_WIDTH, 13, element address width
FIFO_DEPTH, 4, packed-word FIFO entries (power of 2)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
in_data  input  DATA_BIT  element value
in_data_vld  input  1  element valid; no backpressure to upstream
in_data_addr  input  ADDR_WIDTH  element address
in_finish  input  1  end of vector; rising edge is the event
wr_data  output  DATA_BIT*PACK_NUM  packed word; lane k at bits [k*DATA_BIT +: DATA_BIT]
wr_byte_en  output  PACK_NUM  lane write mask
wr_addr  output  ADDR_WIDTH-log2(PACK_NUM)  word address
wr_vld  output  1  write request
wr_rdy  input  1  SRAM accepts the write
out_finish  output  1  one-cycle pulse; all data written
overflow  output  1  sticky; a word was dropped
busy  output  1  open word, FIFO non-empty, or state not IDLE

Behaviour:
- Reset: all outputs 0. FIFO empty, no open word, state IDLE, overflow 0. Async reset mid-transfer discards all content.
- Address split: word address = in_data_addr[ADDR_WIDTH-1:log2 PACK_NUM]; lane = the low log2(PACK_NUM) bits.
- Packing register holds open flag, word address, data, and mask. On in_data_vld:
  - No open word: open it with that address, write the lane, set its mask bit, clear all other mask bits.
  - Open word, same address: write the lane and set its mask bit. A duplicate lane overwrites; last write wins.
  - Open word, different address: push the old word to the FIFO, then open a new word with the incoming byte.
  - If the mask becomes all ones after an insertion, push that word in the same cycle and clear open.
- At most one push per cycle.
- FIFO:
  - Push succeeds if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the word is dropped and overflow is set (cleared only by reset).
- Write port:
  - wr_vld = FIFO non-empty. wr_data/wr_byte_en/wr_addr show the head entry and come directly from registers.
  - Pop when wr_vld && wr_rdy.
  - Outputs stay stable while wr_vld && !wr_rdy.
- Latency: a byte that completes a word at edge T gives wr_vld=1 after edge T+1 when the FIFO was empty (one FIFO write cycle).
- Finish FSM:
  - IDLE -> FLUSH on in_finish rising edge. An edge detect register is reset to 0.
  - FLUSH: if a word is open and the FIFO can accept it, push it and clear open. If the FIFO is full, wait; this case never counts as overflow.
  - FLUSH -> DONE when no word is open and the FIFO is empty.
  - DONE: out_finish=1 for exactly one cycle -> IDLE.
- Simultaneous valid and finish edge: the element is packed first, so the flush includes it.
- in_data_vld during FLUSH/DONE is still packed. DONE is entered only after those words drain too.
- A new finish edge during FLUSH/DONE is ignored.
- The FIFO pointers wrap modulo FIFO_DEPTH, with an extra bit used to tell full from empty.

Test Plan:
1. Addresses 0x010..0x017 with data 1..8, one per cycle, wr_rdy=1 -> one write: wr_addr=0x002, wr_byte_en=0xFF, wr_data=0x0807060504030201, wr_vld high the cycle after the 8th byte.
2. Addresses 0x020, 0x021 (data 0xAA, 0xBB), then 0x030 -> write wr_addr=0x004, be=0x03, data low 16 bits 0xBBAA. Then finish edge -> write wr_addr=0x006, be=0x01, then one out_finish pulse.
3. Lane 3 of word 0x005 written twice (0x11 then 0x22), then finish -> be=0x08, byte3=0x22, no overflow.
4. wr_rdy=0 while 5 full words are produced (depth 4) -> FIFO holds the first 4 and overflow=1. Raise wr_rdy -> 4 writes in order, data stable while stalled.
5. Valid and finish edge in the same cycle at address 0x1FFF with 0x7F -> write wr_addr=0x3FF, be=0x80, then out_finish. Also, finish with nothing pending -> out_finish pulses 2 cycles after the edge.
6. Assert rst_n low with 2 FIFO entries and an open word -> wr_vld=0, busy=0, overflow=0 immediately. No stale writes after release.
